// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and field sizes for the instruction-memory loader
package imem_loader_pkg;

  // Loader sequencing states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_WRITE,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_e;

  // Bytes in the word-count header and in the trailing checksum
  localparam int HDR_BYTES  = 4;
  // Bytes per little-endian instruction word
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in and instruction-memory write port out of the loader
interface imem_loader_if;

  // Host byte stream (UART receiver side)
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  // Instruction-memory write port
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_din;

  // Loader side: consumes the byte stream, drives the memory port
  modport master (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output imem_we,
    output imem_addr,
    output imem_din
  );

  // Environment side: byte source and memory
  modport slave (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  imem_we,
    input  imem_addr,
    input  imem_din
  );

endinterface

// File: rtl/imem_loader_byte_word_assembler.sv
// rtl/imem_loader_byte_word_assembler.sv - gathers four bytes into one little-endian 32-bit word
module byte_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_data_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

  // Only the first three bytes need storage; the fourth is taken straight
  // from the input so the full word is usable on the cycle it completes.
  logic [23:0] sh_q, sh_d;
  logic [1:0]  cnt_q, cnt_d;

  // Next state: clear restarts the field, each accepted byte shifts in from the top
  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      sh_d  = '0;
      cnt_d = '0;
    end else if (byte_valid_i) begin
      sh_d  = {byte_data_i, sh_q[23:8]};
      cnt_d = cnt_q + 2'd1;
    end
  end

  // Byte holding register and position counter (counter wraps for the next field)
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

  assign word_o       = {byte_data_i, sh_q};
  assign word_valid_o = byte_valid_i && !clear_i && (cnt_q == LAST_IDX);

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader: parses count header, writes words to imem, checks sum, releases core
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IMEM_WORDS = 1024,
  parameter int CNT_W      = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          cpu_rstn,
  output logic          busy,
  output logic          done,
  output logic          err
);

  if (HDR_BYTES != WORD_BYTES) begin : g_bad_field_size
    $error("header and word field sizes must match the shared assembler");
  end
  if ((64'd1 << CNT_W) <= 64'(IMEM_WORDS)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for IMEM_WORDS");
  end

  state_e          state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] idx_q;
  logic [CNT_W-1:0] idx_inc;
  logic [31:0]     sum_q;
  logic            we_q;
  logic [31:0]     addr_q;
  logic [31:0]     din_q;
  logic            cpu_rstn_q;
  logic            busy_q;
  logic            done_q;
  logic            err_q;

  logic            rx_ready;
  logic            xfer;
  logic            start_ok;
  logic [31:0]     field_word;
  logic            field_valid;

  assign rx_ready = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_CSUM);
  assign xfer     = bus.rx_valid && rx_ready;
  assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
  assign idx_inc  = idx_q + CNT_W'(1);

  byte_word_assembler u_asm (
    .clk          (clk),
    .rstn         (rstn),
    .clear_i      (start_ok),
    .byte_valid_i (xfer),
    .byte_data_i  (bus.rx_data),
    .word_o       (field_word),
    .word_valid_o (field_valid)
  );

  // Load sequencer with registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      sum_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      cpu_rstn_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state_q    <= ST_HDR;
            idx_q      <= '0;
            sum_q      <= '0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cpu_rstn_q <= 1'b0;
          end
        end
        ST_HDR: begin
          if (field_valid) begin
            // Full 32-bit compare so oversized counts are not masked by CNT_W
            cnt_q <= field_word[CNT_W-1:0];
            if (field_word > 32'(IMEM_WORDS)) begin
              state_q <= ST_ERR;
              busy_q  <= 1'b0;
              err_q   <= 1'b1;
            end else if (field_word == '0) begin
              state_q <= ST_CSUM;
            end else begin
              state_q <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (field_valid) begin
            state_q <= ST_WRITE;
            we_q    <= 1'b1;
            addr_q  <= 32'({idx_q, 2'b00});
            din_q   <= field_word;
          end
        end
        ST_WRITE: begin
          we_q  <= 1'b0;
          sum_q <= sum_q + din_q;
          idx_q <= idx_inc;
          if (idx_inc == cnt_q) begin
            state_q <= ST_CSUM;
          end else begin
            state_q <= ST_DATA;
          end
        end
        ST_CSUM: begin
          if (field_valid) begin
            busy_q <= 1'b0;
            if (field_word == sum_q) begin
              state_q    <= ST_DONE;
              done_q     <= 1'b1;
              cpu_rstn_q <= 1'b1;
            end else begin
              state_q <= ST_ERR;
              err_q   <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.rx_ready  = rx_ready;
  assign bus.imem_we   = we_q;
  assign bus.imem_addr = addr_q;
  assign bus.imem_din  = din_q;
  assign cpu_rstn      = cpu_rstn_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

  localparam int IMEM_WORDS = 1024;

  logic clk   = 1'b0;
  logic rstn  = 1'b0;
  logic start = 1'b0;
  logic cpu_rstn, busy, done, err;

  imem_loader_if bus ();

  imem_loader #(.IMEM_WORDS(IMEM_WORDS), .CNT_W(16)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .bus      (bus),
    .cpu_rstn (cpu_rstn),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int xfer_cnt = 0;
  int start_at = -1;
  int gap_max  = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic [31:0] wbuf[8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Record every memory write; a stuck enable shows up as extra entries
  always @(negedge clk) begin
    if (bus.imem_we) begin
      wr_addr.push_back(bus.imem_addr);
      wr_data.push_back(bus.imem_din);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    @(negedge clk);
    if (start_at == xfer_cnt) begin
      bus.rx_valid = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("midload_busy", 32'(busy), 1);
      check("midload_done", 32'(done), 0);
      start_at = -1;
    end
    if (gap_max > 0) begin
      int g;
      g = $urandom_range(0, gap_max);
      repeat (g) begin
        bus.rx_valid = 1'b0;
        @(negedge clk);
      end
    end
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    t = 0;
    while (!bus.rx_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      check("rx_accept_timeout", 0, 1);
      bus.rx_valid = 1'b0;
    end else begin
      @(posedge clk);
      xfer_cnt++;
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic end_stream();
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    xfer_cnt = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_rx_ready", 32'(bus.rx_ready), 0);
    check("rst_we", 32'(bus.imem_we), 0);
    check("rst_addr", bus.imem_addr, 0);
    check("rst_din", bus.imem_din, 0);
    check("rst_cpu_rstn", 32'(cpu_rstn), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    rstn = 1'b1;

    // Valid bytes while idle are not consumed
    @(negedge clk);
    bus.rx_data = 8'haa;
    bus.rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_ready", 32'(bus.rx_ready), 0);
    bus.rx_valid = 1'b0;

    // Two-word load, gap-free
    clear_log();
    pulse_start();
    check("t2_busy", 32'(busy), 1);
    check("t2_rx_ready", 32'(bus.rx_ready), 1);
    send_word(32'd2);
    send_word(32'h3e800093);
    #1;
    check("t2_we_latency", 32'(bus.imem_we), 1);
    check("t2_we_addr", bus.imem_addr, 32'h0);
    send_word(32'h83000113);
    send_word(32'hc18001a6);
    end_stream();
    check("t2_nwr", wr_addr.size(), 2);
    check("t2_addr0", wr_addr[0], 32'h0);
    check("t2_din0", wr_data[0], 32'h3e800093);
    check("t2_addr1", wr_addr[1], 32'h4);
    check("t2_din1", wr_data[1], 32'h83000113);
    check("t2_done", 32'(done), 1);
    check("t2_cpu_rstn", 32'(cpu_rstn), 1);
    check("t2_err", 32'(err), 0);
    check("t2_busy_end", 32'(busy), 0);

    // Restart from DONE, oversized header
    clear_log();
    pulse_start();
    check("t3_done_clr", 32'(done), 0);
    check("t3_cpu_rstn_clr", 32'(cpu_rstn), 0);
    check("t3_busy", 32'(busy), 1);
    send_word(32'(IMEM_WORDS + 1));
    end_stream();
    check("t3_err", 32'(err), 1);
    check("t3_busy_end", 32'(busy), 0);
    check("t3_cpu_rstn", 32'(cpu_rstn), 0);
    check("t3_rx_ready", 32'(bus.rx_ready), 0);
    check("t3_nwr", wr_addr.size(), 0);

    // One word with a wrong checksum
    clear_log();
    pulse_start();
    check("t4_err_clr", 32'(err), 0);
    send_word(32'd1);
    send_word(32'h001001b3);
    send_word(32'h00000000);
    end_stream();
    check("t4_nwr", wr_addr.size(), 1);
    check("t4_addr0", wr_addr[0], 32'h0);
    check("t4_din0", wr_data[0], 32'h001001b3);
    check("t4_err", 32'(err), 1);
    check("t4_done", 32'(done), 0);
    check("t4_cpu_rstn", 32'(cpu_rstn), 0);

    // Empty program
    clear_log();
    pulse_start();
    send_word(32'd0);
    send_word(32'd0);
    end_stream();
    check("t5_xfer", xfer_cnt, 8);
    check("t5_nwr", wr_addr.size(), 0);
    check("t5_done", 32'(done), 1);
    check("t5_cpu_rstn", 32'(cpu_rstn), 1);

    // Random gaps with an ignored start mid-load
    clear_log();
    wbuf[0] = 32'h11223344;
    wbuf[1] = 32'hdeadbeef;
    wbuf[2] = 32'h00000001;
    wbuf[3] = 32'hffffffff;
    pulse_start();
    gap_max  = 3;
    start_at = 9;
    send_word(32'd4);
    for (int i = 0; i < 4; i++) send_word(wbuf[i]);
    send_word(32'hefcff233);
    end_stream();
    gap_max = 0;
    check("t6_nwr", wr_addr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t6_addr%0d", i), wr_addr[i], 32'(i * 4));
      check($sformatf("t6_din%0d", i), wr_data[i], wbuf[i]);
    end
    check("t6_done", 32'(done), 1);
    check("t6_err", 32'(err), 0);

    // Async reset while assembling word 3, then a clean reload
    clear_log();
    pulse_start();
    send_word(32'd5);
    for (int i = 0; i < 3; i++) send_word(32'h01010101 * (i + 1));
    send_byte(8'h55);
    send_byte(8'h66);
    #2;
    rstn = 1'b0;
    #1;
    check("t7_rx_ready", 32'(bus.rx_ready), 0);
    check("t7_we", 32'(bus.imem_we), 0);
    check("t7_addr", bus.imem_addr, 0);
    check("t7_din", bus.imem_din, 0);
    check("t7_cpu_rstn", 32'(cpu_rstn), 0);
    check("t7_busy", 32'(busy), 0);
    check("t7_done", 32'(done), 0);
    check("t7_err", 32'(err), 0);
    check("t7_nwr_before", wr_addr.size(), 3);
    bus.rx_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    clear_log();
    pulse_start();
    send_word(32'd2);
    send_word(32'h00500093);
    send_word(32'h00a00113);
    send_word(32'h00f001a6);
    end_stream();
    check("t7_nwr", wr_addr.size(), 2);
    check("t7_addr0", wr_addr[0], 32'h0);
    check("t7_din0", wr_data[0], 32'h00500093);
    check("t7_addr1", wr_addr[1], 32'h4);
    check("t7_din1", wr_data[1], 32'h00a00113);
    check("t7_done_end", 32'(done), 1);
    check("t7_cpu_rstn_end", 32'(cpu_rstn), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
